// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode encodings plus the scoreboard slot record used by the hazard unit.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    // Slot register field is sized for the largest supported register file (32).
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned FWD_REGFILE = 0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wsel;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wsel: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: master is the datapath, slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNTW  = 16
);
    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned FW = $clog2(DEPTH);

    logic            id_valid;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_wen;
    logic [RW-1:0]   id_wsel;
    logic            id_load;
    logic            mem_busy;
    logic            ex_redirect;
    logic            stall;
    logic            freeze;
    logic            flush;
    logic [FW-1:0]   fwd_rs;
    logic [FW-1:0]   fwd_rt;
    logic [NREGS-1:0] busy_map;
    logic [CNTW-1:0] load_use_cnt;
    logic [CNTW-1:0] freeze_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_wsel, id_load,
               mem_busy, ex_redirect,
        input  stall, freeze, flush, fwd_rs, fwd_rt, busy_map, load_use_cnt, freeze_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_wsel, id_load,
               mem_busy, ex_redirect,
        output stall, freeze, flush, fwd_rs, fwd_rt, busy_map, load_use_cnt, freeze_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// One source operand against the in-flight slots: youngest match, its readiness next cycle, forward select.
module hazard_match
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned RW         = 5,
    parameter int unsigned FW         = 2
) (
    input  logic [RW-1:0]    src_i,
    input  logic             use_i,
    input  slot_t [DEPTH-1:0] slots_i,
    output logic             hit_o,
    output logic             ready_o,
    output logic [FW-1:0]    fwd_o
);

    // k is the slot the producer will occupy next cycle; scanning oldest-first lets the youngest win.
    always_comb begin
        hit_o   = 1'b0;
        ready_o = 1'b0;
        fwd_o   = FW'(FWD_REGFILE);
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (use_i && (src_i != '0) && slots_i[k-1].valid &&
                (slots_i[k-1].wsel == REG_AW'(src_i))) begin
                hit_o   = 1'b1;
                ready_o = (k >= (slots_i[k-1].is_load ? LOAD_READY : ALU_READY));
                fwd_o   = (ready_o && (k <= DEPTH-1)) ? FW'(k) : FW'(FWD_REGFILE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: in-flight write slots, forwarding selects, stall/flush/freeze and perf counters.
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS      = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNTW       = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    hazard_scoreboard_if.slave hif
);

    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned FW = $clog2(DEPTH);

    slot_t [DEPTH-1:0] slots_q, slots_d;
    logic [CNTW-1:0]   load_use_cnt_q, load_use_cnt_d;
    logic [CNTW-1:0]   freeze_cnt_q, freeze_cnt_d;
    logic              rs_hit, rs_ready, rt_hit, rt_ready;
    logic [FW-1:0]     fwd_rs, fwd_rt;
    logic              stall, freeze, flush;
    logic [NREGS-1:0]  busy_map;

    hazard_match #(
        .DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW)
    ) u_match_rs (
        .src_i(hif.id_rs), .use_i(hif.id_use_rs), .slots_i(slots_q),
        .hit_o(rs_hit), .ready_o(rs_ready), .fwd_o(fwd_rs)
    );

    hazard_match #(
        .DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW)
    ) u_match_rt (
        .src_i(hif.id_rt), .use_i(hif.id_use_rt), .slots_i(slots_q),
        .hit_o(rt_hit), .ready_o(rt_ready), .fwd_o(fwd_rt)
    );

    always_comb begin
        freeze = hif.mem_busy;
        flush  = hif.ex_redirect & ~hif.mem_busy;
        stall  = hif.id_valid & ~flush & ~freeze &
                 ((rs_hit & ~rs_ready) | (rt_hit & ~rt_ready));
    end

    always_comb begin
        slots_d = slots_q;
        if (!freeze) begin
            for (int unsigned i = DEPTH-1; i > 0; i--) begin
                slots_d[i] = slots_q[i-1];
            end
            slots_d[0] = SLOT_EMPTY;
            if (hif.id_valid && hif.id_wen && (hif.id_wsel != '0) && !stall && !flush) begin
                slots_d[0] = '{valid: 1'b1, wsel: REG_AW'(hif.id_wsel), is_load: hif.id_load};
            end
        end
    end

    always_comb begin
        busy_map = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slots_q[i].valid) begin
                busy_map[slots_q[i].wsel] = 1'b1;
            end
        end
    end

    always_comb begin
        load_use_cnt_d = load_use_cnt_q;
        freeze_cnt_d   = freeze_cnt_q;
        if (stall && (load_use_cnt_q != '1)) load_use_cnt_d = load_use_cnt_q + 1'b1;
        if (freeze && (freeze_cnt_q != '1))  freeze_cnt_d   = freeze_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slots_q        <= '0;
            load_use_cnt_q <= '0;
            freeze_cnt_q   <= '0;
        end else begin
            slots_q        <= slots_d;
            load_use_cnt_q <= load_use_cnt_d;
            freeze_cnt_q   <= freeze_cnt_d;
        end
    end

    assign hif.stall        = stall;
    assign hif.freeze       = freeze;
    assign hif.flush        = flush;
    assign hif.fwd_rs       = fwd_rs;
    assign hif.fwd_rt       = fwd_rt;
    assign hif.busy_map     = busy_map;
    assign hif.load_use_cnt = load_use_cnt_q;
    assign hif.freeze_cnt   = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed expectations for forwarding, stalls, flush, freeze, reset.
module tb_hazard_scoreboard;

    logic CLK;
    logic nRST;
    int unsigned checks;
    int unsigned errors;

    hazard_scoreboard_if #(.NREGS(32), .DEPTH(3), .CNTW(4)) hif ();

    hazard_scoreboard #(
        .NREGS(32), .DEPTH(3), .ALU_READY(1), .LOAD_READY(2), .CNTW(4)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .hif(hif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic wen, input logic [4:0] ws, input logic ld);
        hif.id_valid  = v;
        hif.id_rs     = rs;
        hif.id_use_rs = urs;
        hif.id_rt     = rt;
        hif.id_use_rt = urt;
        hif.id_wen    = wen;
        hif.id_wsel   = ws;
        hif.id_load   = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRST = 1'b0;
        hif.mem_busy = 1'b1;
        hif.ex_redirect = 1'b0;
        idle();

        // reset state
        #2;
        chk("rst_freeze", hif.freeze, 1);
        chk("rst_stall", hif.stall, 0);
        chk("rst_flush", hif.flush, 0);
        chk("rst_fwd_rs", hif.fwd_rs, 0);
        chk("rst_fwd_rt", hif.fwd_rt, 0);
        chk("rst_busy", hif.busy_map, 0);
        chk("rst_lu_cnt", hif.load_use_cnt, 0);
        chk("rst_fr_cnt", hif.freeze_cnt, 0);
        hif.mem_busy = 1'b0;
        #1;
        chk("rst_freeze_low", hif.freeze, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // ADD r3,r1,r2 ; SUB r4,r3,r1 back to back
        cyc(); drive(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0);
        @(negedge CLK);
        chk("add_stall", hif.stall, 0);
        chk("add_busy", hif.busy_map, 0);
        cyc(); drive(1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0);
        @(negedge CLK);
        chk("sub_stall", hif.stall, 0);
        chk("sub_fwd_rs", hif.fwd_rs, 1);
        chk("sub_fwd_rt", hif.fwd_rt, 0);
        chk("sub_busy", hif.busy_map, 32'h8);
        cyc(); drive(1, 5'd4, 1, 5'd3, 1, 0, 5'd0, 0);
        @(negedge CLK);
        chk("rd1_fwd_rs", hif.fwd_rs, 1);
        chk("rd1_fwd_rt", hif.fwd_rt, 2);
        chk("rd1_busy", hif.busy_map, 32'h18);
        chk("rd1_stall", hif.stall, 0);
        cyc(); drive(1, 5'd3, 1, 5'd4, 1, 0, 5'd0, 0);
        @(negedge CLK);
        chk("retire_fwd_rs", hif.fwd_rs, 0);
        chk("rd2_fwd_rt", hif.fwd_rt, 2);
        chk("rd2_busy", hif.busy_map, 32'h18);
        cyc(); idle();
        @(negedge CLK);
        chk("drain1_busy", hif.busy_map, 32'h10);
        cyc();
        @(negedge CLK);
        chk("drain2_busy", hif.busy_map, 0);

        // LW r5 ; ADD r6,r5,r5 load-use
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1);
        @(negedge CLK);
        chk("lw_stall", hif.stall, 0);
        cyc(); drive(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0);
        @(negedge CLK);
        chk("lu_stall", hif.stall, 1);
        chk("lu_cnt0", hif.load_use_cnt, 0);
        cyc();
        @(negedge CLK);
        chk("lu_stall_end", hif.stall, 0);
        chk("lu_fwd_rs", hif.fwd_rs, 2);
        chk("lu_fwd_rt", hif.fwd_rt, 2);
        chk("lu_cnt1", hif.load_use_cnt, 1);
        cyc(); idle();
        @(negedge CLK);
        chk("lu_busy", hif.busy_map, 32'h60);
        chk("lu_cnt_hold", hif.load_use_cnt, 1);
        cyc(); cyc(); cyc();
        @(negedge CLK);
        chk("lu_drain_busy", hif.busy_map, 0);

        // write to r0 then read r0
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 0);
        @(negedge CLK);
        chk("r0w_stall", hif.stall, 0);
        cyc(); drive(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
        @(negedge CLK);
        chk("r0_busy", hif.busy_map, 0);
        chk("r0_stall", hif.stall, 0);
        chk("r0_fwd_rs", hif.fwd_rs, 0);
        chk("r0_fwd_rt", hif.fwd_rt, 0);

        // load-use coinciding with redirect
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1);
        cyc(); drive(1, 5'd7, 1, 5'd0, 0, 1, 5'd8, 0);
        hif.ex_redirect = 1'b1;
        @(negedge CLK);
        chk("rd_flush", hif.flush, 1);
        chk("rd_stall", hif.stall, 0);
        chk("rd_busy", hif.busy_map, 32'h80);
        cyc(); idle();
        hif.ex_redirect = 1'b0;
        @(negedge CLK);
        chk("rd_bubble_busy", hif.busy_map, 32'h80);
        chk("rd_lu_cnt", hif.load_use_cnt, 1);
        chk("rd_flush_off", hif.flush, 0);
        cyc(); cyc();
        @(negedge CLK);
        chk("rd_drain_busy", hif.busy_map, 0);

        // mem_busy for 4 cycles with LW r9 in slot 1
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd9, 1);
        cyc(); idle();
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(); drive(1, 5'd9, 1, 5'd0, 0, 1, 5'd10, 0);
            hif.mem_busy = 1'b1;
            @(negedge CLK);
            chk("frz_freeze", hif.freeze, 1);
            chk("frz_stall", hif.stall, 0);
            chk("frz_fwd_rs", hif.fwd_rs, 2);
            chk("frz_busy", hif.busy_map, 32'h200);
            chk("frz_cnt", hif.freeze_cnt, i);
        end
        cyc();
        hif.mem_busy = 1'b0;
        @(negedge CLK);
        chk("unfrz_freeze", hif.freeze, 0);
        chk("unfrz_stall", hif.stall, 0);
        chk("unfrz_fwd_rs", hif.fwd_rs, 2);
        chk("unfrz_cnt", hif.freeze_cnt, 4);
        chk("unfrz_busy", hif.busy_map, 32'h200);
        cyc(); idle();
        @(negedge CLK);
        chk("unfrz_adv_busy", hif.busy_map, 32'h600);

        // redirect held across freeze
        cyc();
        hif.mem_busy = 1'b1;
        hif.ex_redirect = 1'b1;
        @(negedge CLK);
        chk("fr_rd_freeze", hif.freeze, 1);
        chk("fr_rd_flush", hif.flush, 0);
        cyc();
        hif.mem_busy = 1'b0;
        @(negedge CLK);
        chk("fr_rd_flush_rel", hif.flush, 1);
        chk("fr_rd_freeze_rel", hif.freeze, 0);
        chk("fr_rd_cnt", hif.freeze_cnt, 5);

        // saturation of the 4-bit freeze counter
        cyc();
        hif.ex_redirect = 1'b0;
        hif.mem_busy = 1'b1;
        repeat (14) cyc();
        hif.mem_busy = 1'b0;
        @(negedge CLK);
        chk("sat_fr_cnt", hif.freeze_cnt, 15);
        chk("sat_lu_cnt", hif.load_use_cnt, 1);

        // asynchronous reset with three valid slots
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0);
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd12, 0);
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd13, 0);
        cyc(); idle();
        chk("pre_rst_busy", hif.busy_map, 32'h3800);
        #1 nRST = 1'b0;
        #1;
        chk("arst_busy", hif.busy_map, 0);
        chk("arst_lu_cnt", hif.load_use_cnt, 0);
        chk("arst_fr_cnt", hif.freeze_cnt, 0);
        drive(1, 5'd13, 1, 5'd12, 1, 0, 5'd0, 0);
        #1;
        chk("arst_fwd_rs", hif.fwd_rs, 0);
        chk("arst_fwd_rt", hif.fwd_rt, 0);
        chk("arst_stall", hif.stall, 0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(); drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd14, 0);
        @(negedge CLK);
        chk("post_rst_busy", hif.busy_map, 0);
        cyc(); drive(1, 5'd13, 1, 5'd12, 1, 0, 5'd0, 0);
        @(negedge CLK);
        chk("post_rst_fwd_rs", hif.fwd_rs, 0);
        chk("post_rst_fwd_rt", hif.fwd_rt, 0);
        chk("post_rst_busy2", hif.busy_map, 32'h4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard unit. Tracks every in-flight register write in a shift-register scoreboard of DEPTH slots behind ID. From that state it produces:
- per-source forwarding selects,
- load-use stalls,
- branch-redirect flushes,
- a memory-wait freeze.

It also keeps saturating stall counters for performance analysis. It sits beside the ID stage; the datapath applies its outputs to the IF/ID and ID/EX latches.

## Interface
- NREGS, 32, architectural register count; register 0 is hardwired zero.
- DEPTH, 3, in-flight slots: slot 0 = ID/EX, slot 1 = EX/MEM, slot DEPTH-1 = MEM/WB; minimum 2.
- ALU_READY, 1, first slot from which a non-load result is forwardable.
- LOAD_READY, 2, first slot from which load data is forwardable; must be ≥ ALU_READY and ≤ DEPTH-1.
- CNTW, 16, counter width.

Derived localparams: RW = $clog2(NREGS), FW = $clog2(DEPTH).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  RW  source register numbers.
- id_use_rs, id_use_rt  in  1  source actually read.
- id_wen  in  1  instruction writes a register.
- id_wsel  in  RW  destination register.
- id_load  in  1  instruction is a load.
- mem_busy  in  1  MEM stage waiting on dcache (request and no dhit).
- ex_redirect  in  1  EX resolved a taken branch, jump or jr.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- freeze  out  1  hold every pipeline latch.
- flush  out  1  squash IF/ID.
- fwd_rs, fwd_rt  out  FW  operand source for the next EX cycle: 0 = register file, k = slot k.
- busy_map  out  NREGS  bit r set while any valid slot targets r.
- load_use_cnt, freeze_cnt  out  CNTW  saturating performance counters.

## Operation
- Slot entry contents: valid, wsel, is_load. An entry is never created with wsel=0 or with id_wen=0.
- Source match:
  - A source matches a slot when use=1, the register is nonzero, the slot is valid, and wsel is equal.
  - The youngest (lowest-index) matching slot wins.
- Readiness, evaluated for the cycle after the instruction advances:
  - A producer in slot k will sit in slot k+1.
  - It is ready iff k+1 ≥ (is_load ? LOAD_READY : ALU_READY).
  - Ready, k+1 ≤ DEPTH-1: fwd = k+1.
  - Producer in slot DEPTH-1 (retiring this cycle): fwd = 0. The register file is write-first.
  - No match: fwd = 0.
- Output priority, highest first:
  1. freeze = mem_busy.
  2. flush = ex_redirect & ~mem_busy.
  3. stall = id_valid & ~flush & ~freeze & (either used source has a not-ready youngest match).
- Shift, when ~freeze:
  - Slot i+1 ← slot i; slot DEPTH-1 retires.
  - Slot 0 ← the ID entry if id_valid & id_wen & ~stall & ~flush, otherwise an invalid bubble.
- Under freeze: all slots hold, and the outputs are recomputed from the held state.
- Counters, each saturating at 2^CNTW-1:
  - load_use_cnt += 1 on every cycle with stall=1.
  - freeze_cnt += 1 on every cycle with freeze=1.

## Timing
- Outputs are combinational from current inputs and slot state; there is zero latency to the same-cycle latch enables.
- Slot and counter updates happen at the rising edge of CLK.
- Reset (asynchronous, takes effect mid-operation): all slots invalid, counters 0, busy_map 0. Consequently stall=0, flush=0, fwd=0, and freeze follows mem_busy.
- ALU back-to-back dependency: no stall, fwd=1.
- Load-use dependency with defaults: exactly one stall cycle, then fwd=2.
- Producer two slots ahead at DEPTH=3: fwd=0.
- ex_redirect together with a load-use hazard: flush=1, stall=0, and a bubble enters slot 0.
- mem_busy together with ex_redirect: flush is suppressed until mem_busy drops. The datapath holds ex_redirect while frozen.
- A counter at its maximum value stays there.

## Structure
- Shared package: slot_t {valid, wsel, is_load} and the FWD_REGFILE = 0 constant go into cpu_types_pkg, beside the opcode types.
- One sub-module, hazard_match:
  - Inputs: one source (reg, use) plus the slot array.
  - Outputs: hit, ready, fwd select.
  - Instantiated twice, for rs and rt.
- The top level holds the slot shift register, priority logic, busy_map and counters.

## Test plan
- ADD r3 then SUB r4,r3,r1 issued consecutively -> stall=0, fwd_rs=1; busy_map[3]=1 for 3 cycles.
- LW r5 then ADD r6,r5,r5 -> stall=1 for exactly one cycle, fwd_rs=fwd_rt=2 afterwards, load_use_cnt=1.
- Write to r0 followed by a reader of r0 -> no slot created, stall=0, fwd=0.
- Load-use hazard coinciding with ex_redirect=1 -> flush=1, stall=0, slot 0 bubble, load_use_cnt unchanged.
- mem_busy held 4 cycles with a pending LW in slot 1 -> freeze=1, slots unchanged, freeze_cnt=4; dependency resolves normally after release.
- nRST pulsed low mid-stream with 3 valid slots -> busy_map=0 and counters=0 immediately (asynchronously); first post-reset dependent pair gets fwd=0.
